// File: rtl/mmio_calc_if.sv
// Memory-mapped register bus for mmio_calc_unit.
// Requester holds bus_valid until the one-cycle bus_ready pulse.
interface mmio_calc_if #(
  parameter int XLEN  = 32,
  parameter int ABITS = 5
);
  logic             bus_valid;
  logic             bus_we;
  logic [ABITS-1:0] bus_addr;
  logic [XLEN-1:0]  bus_wdata;
  logic [XLEN-1:0]  bus_rdata;
  logic             bus_ready;

  modport master (
    output bus_valid,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ready
  );

  modport slave (
    input  bus_valid,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ready
  );
endinterface

// File: rtl/mmio_calc_unit.sv
// MMIO calculator: A/B/OP registers, start via CTRL, result via RESULT.
// Define MMIO_CALC_MUL_EN to make OP=3 a shift-add MUL instead of XOR.
module mmio_calc_unit #(
  parameter int XLEN  = 32,
  parameter int ABITS = 5
) (
  input  logic            clk,
  input  logic            rst,
  mmio_calc_if.slave      bus,
  output logic [XLEN-1:0] io_out_res,
  output logic            io_out_valid,
  output logic            busy
);

  localparam logic [ABITS-1:0] ADDR_A    = ABITS'(8'h00);
  localparam logic [ABITS-1:0] ADDR_B    = ABITS'(8'h04);
  localparam logic [ABITS-1:0] ADDR_OP   = ABITS'(8'h08);
  localparam logic [ABITS-1:0] ADDR_CTRL = ABITS'(8'h0C);
  localparam logic [ABITS-1:0] ADDR_STAT = ABITS'(8'h10);
  localparam logic [ABITS-1:0] ADDR_RES  = ABITS'(8'h14);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] sa;
  logic [XLEN-1:0] sb;
  logic [1:0]      sop;
  logic            overrun;

  logic            acc_go;
  logic            wr_go;
  logic            hit_a;
  logic            hit_b;
  logic            hit_op;
  logic            hit_ctrl;
  logic            hit_stat;
  logic            hit_res;
  logic            cfg_wr;
  logic            cfg_we;
  logic            start;
  logic            ovr_set;
  logic            ovr_clr;
  logic            last;
  logic            run_end;
  logic [XLEN-1:0] res_nx;
  logic [XLEN-1:0] rd_mux;

`ifdef MMIO_CALC_MUL_EN
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            is_mul;
  logic [XLEN-1:0] mul_nx;
`endif

  // An access is taken on the edge that raises bus_ready.
  assign acc_go   = bus.bus_valid && !bus.bus_ready;
  assign wr_go    = acc_go && bus.bus_we;
  assign hit_a    = bus.bus_addr == ADDR_A;
  assign hit_b    = bus.bus_addr == ADDR_B;
  assign hit_op   = bus.bus_addr == ADDR_OP;
  assign hit_ctrl = bus.bus_addr == ADDR_CTRL;
  assign hit_stat = bus.bus_addr == ADDR_STAT;
  assign hit_res  = bus.bus_addr == ADDR_RES;
  assign cfg_wr   = wr_go && (hit_a || hit_b || hit_op || hit_ctrl);
  assign cfg_we   = cfg_wr && !busy;
  assign ovr_set  = cfg_wr && busy;
  assign ovr_clr  = wr_go && hit_stat && bus.bus_wdata[2];
  assign start    = cfg_we && hit_ctrl && bus.bus_wdata[0];

`ifdef MMIO_CALC_MUL_EN
  assign is_mul = sop == 2'd3;
  assign mul_nx = mul_acc + (mplier[0] ? mcand : '0);
  assign last   = !is_mul || (cnt == CW'(XLEN - 1));
`else
  assign last   = 1'b1;
`endif

  always_comb begin
    res_nx = '0;
    unique case (sop)
      2'd0: res_nx = sa + sb;
      2'd1: res_nx = sa - sb;
      2'd2: res_nx = sa & sb;
`ifdef MMIO_CALC_MUL_EN
      2'd3: res_nx = mul_nx;
`else
      2'd3: res_nx = sa ^ sb;
`endif
      default: res_nx = '0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_a:    rd_mux = a_q;
      hit_b:    rd_mux = b_q;
      hit_op:   rd_mux = {{(XLEN-2){1'b0}}, op_q};
      hit_stat: rd_mux = {{(XLEN-3){1'b0}}, overrun, io_out_valid, busy};
      hit_res:  rd_mux = io_out_res;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = state != IDLE;
    run_end = (state == RUN) && last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_ready <= 1'b0;
      bus.bus_rdata <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      sa            <= '0;
      sb            <= '0;
      sop           <= '0;
      overrun       <= 1'b0;
      io_out_res    <= '0;
      io_out_valid  <= 1'b0;
    end else begin
      bus.bus_ready <= acc_go;
      bus.bus_rdata <= acc_go ? rd_mux : '0;
      if (cfg_we && hit_a)  a_q  <= bus.bus_wdata;
      if (cfg_we && hit_b)  b_q  <= bus.bus_wdata;
      if (cfg_we && hit_op) op_q <= bus.bus_wdata[1:0];
      if (start) begin
        sa           <= a_q;
        sb           <= b_q;
        sop          <= op_q;
        io_out_valid <= 1'b0;
      end
      if (run_end) begin
        io_out_res   <= res_nx;
        io_out_valid <= 1'b1;
      end
      // A rejected write on the same edge as the clear keeps the flag.
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

`ifdef MMIO_CALC_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (start) begin
      mul_acc <= '0;
      mcand   <= a_q;
      mplier  <= b_q;
      cnt     <= '0;
    end else if (state == RUN && is_mul) begin
      mul_acc <= mul_nx;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_calc_unit.sv
// Directed bench for mmio_calc_unit with a read-data scoreboard.
// Expected MUL/XOR behaviour follows MMIO_CALC_MUL_EN.
module tb_mmio_calc_unit;
  localparam int XLEN  = 32;
  localparam int ABITS = 5;

  localparam logic [ABITS-1:0] R_A    = 5'h00;
  localparam logic [ABITS-1:0] R_B    = 5'h04;
  localparam logic [ABITS-1:0] R_OP   = 5'h08;
  localparam logic [ABITS-1:0] R_CTRL = 5'h0C;
  localparam logic [ABITS-1:0] R_STAT = 5'h10;
  localparam logic [ABITS-1:0] R_RES  = 5'h14;
  localparam logic [ABITS-1:0] R_BAD  = 5'h18;

`ifdef MMIO_CALC_MUL_EN
  localparam logic [XLEN-1:0] EXP3 = 32'd189;
  localparam int              CYC3 = XLEN + 1;
`else
  localparam logic [XLEN-1:0] EXP3 = 32'd28;
  localparam int              CYC3 = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] io_out_res;
  logic            io_out_valid;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] exp_q[$];
  string           tag_q[$];

  always #5 clk = ~clk;

  mmio_calc_if #(.XLEN(XLEN), .ABITS(ABITS)) bus ();

  mmio_calc_unit #(.XLEN(XLEN), .ABITS(ABITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .io_out_res   (io_out_res),
    .io_out_valid (io_out_valid),
    .busy         (busy)
  );

  task automatic check(input string tag,
                       input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input  logic             we,
                        input  logic [ABITS-1:0] a,
                        input  logic [XLEN-1:0]  d,
                        output logic [XLEN-1:0]  rd,
                        output bit               ok);
    @(negedge clk);
    bus.bus_valid = 1'b1;
    bus.bus_we    = we;
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.bus_ready) ok = 1'b1;
    end
    rd = bus.bus_rdata;
    bus.bus_valid = 1'b0;
    n_chk++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL bus_timeout: observed no ready expected ready at addr %0h", a);
    end
  endtask

  task automatic wr(input logic [ABITS-1:0] a, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] rd;
    bit              ok;
    access(1'b1, a, d, rd, ok);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [ABITS-1:0] a,
                        input logic [XLEN-1:0] exp);
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] e;
    string           t;
    bit              ok;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    access(1'b0, a, '0, rd, ok);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (ok) check(t, rd, e);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rcnt;
    bus.bus_valid = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", XLEN'(busy), 32'd0);
    check("rst_valid", XLEN'(io_out_valid), 32'd0);
    check("rst_res", io_out_res, 32'd0);
    check("rst_ready", XLEN'(bus.bus_ready), 32'd0);
    check("rst_rdata", bus.bus_rdata, 32'd0);

    @(negedge clk);
    rst           = 1'b0;
    bus.bus_valid = 1'b1;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = R_A;
    @(posedge clk);
    #1;
    check("first_ready", XLEN'(bus.bus_ready), 32'd1);
    check("first_rdata", bus.bus_rdata, 32'd0);
    bus.bus_valid = 1'b0;

    wr(R_A, 32'd21);
    wr(R_B, 32'd9);
    wr(R_OP, 32'd0);
    rd_chk("rd_a", R_A, 32'd21);
    rd_chk("rd_b", R_B, 32'd9);
    wr(R_CTRL, 32'd1);
    check("add_busy", XLEN'(busy), 32'd1);
    wait_idle(n);
    check("add_cycles", XLEN'(n), 32'd2);
    rd_chk("add_res", R_RES, 32'd30);
    check("add_valid", XLEN'(io_out_valid), 32'd1);
    check("add_out", io_out_res, 32'd30);
    rd_chk("status_v", R_STAT, 32'd2);

    wr(R_OP, 32'd1);
    wr(R_CTRL, 32'd1);
    check("valid_clr", XLEN'(io_out_valid), 32'd0);
    check("res_hold", io_out_res, 32'd30);
    wait_idle(n);
    rd_chk("sub_res", R_RES, 32'd12);

    wr(R_A, 32'd0);
    wr(R_B, 32'd1);
    wr(R_CTRL, 32'd1);
    wait_idle(n);
    rd_chk("sub_wrap", R_RES, 32'hFFFF_FFFF);

    wr(R_A, 32'd21);
    wr(R_B, 32'd9);
    wr(R_OP, 32'd2);
    wr(R_CTRL, 32'd1);
    wait_idle(n);
    rd_chk("and_res", R_RES, 32'd1);

    wr(R_OP, 32'd3);
    wr(R_CTRL, 32'd1);
    wait_idle(n);
    check("op3_cycles", XLEN'(n), XLEN'(CYC3));
    rd_chk("op3_res", R_RES, EXP3);

    wr(R_CTRL, 32'd1);
    wr(R_A, 32'd5);
    wait_idle(n);
    rd_chk("ovr_a", R_A, 32'd21);
    rd_chk("ovr_stat", R_STAT, 32'd6);
    rd_chk("ovr_res", R_RES, EXP3);
    wr(R_STAT, 32'd4);
    rd_chk("ovr_clr", R_STAT, 32'd2);

    rd_chk("ctrl_rd", R_CTRL, 32'd0);
    wr(R_BAD, 32'hDEAD_BEEF);
    rd_chk("bad_rd", R_BAD, 32'd0);
    wr(R_OP, 32'd7);
    rd_chk("op_mask", R_OP, 32'd3);

    @(negedge clk);
    bus.bus_valid = 1'b1;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = R_A;
    rcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.bus_ready) rcnt++;
    end
    bus.bus_valid = 1'b0;
    check("b2b_ready", XLEN'(rcnt), 32'd2);

    wr(R_CTRL, 32'd1);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", XLEN'(busy), 32'd0);
    check("abort_valid", XLEN'(io_out_valid), 32'd0);
    check("abort_res", io_out_res, 32'd0);
    check("abort_ready", XLEN'(bus.bus_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("abort_a", R_A, 32'd0);
    rd_chk("abort_rres", R_RES, 32'd0);

    wr(R_A, 32'd3);
    wr(R_B, 32'd4);
    wr(R_OP, 32'd0);
    wr(R_CTRL, 32'd1);
    wait_idle(n);
    rd_chk("post_add", R_RES, 32'd7);
    check("post_out", io_out_res, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
